vga_timing_core: RTL and testbench

VGA_TIMING_CORE -- requirements
Module: vga_timing_core

---
 rtl/vga_timing_core_if.sv | 42 ++++
 rtl/vga_timing_core.sv | 209 ++++++++++++++++++++
 tb/tb_vga_timing_core.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_core_if.sv
// -----------------------------------------------------------------------------
// vga_timing_core_if
// Bundles the pattern/video signals of the VGA timing core.
//   master : the timing core (drives colour, syncs, counts, pix_req;
//            receives mode, solid_rgb, pix_in)
//   slave  : the consumer/controller side (drives mode, solid_rgb, pix_in)
// Signals:
//   mode[1:0]        pattern select (00 solid, 01 bars, 10 checker, 11 external)
//   solid_rgb[7:0]   {r[2:0],g[2:0],b[1:0]} colour for the solid pattern
//   pix_in[7:0]      external pixel, same packing
//   pix_req          combinational request for pix_in on the current strobe
//   r/g/b            registered colour (3/3/2 bits)
//   hsync/vsync      registered sync levels
//   bright           registered active-video flag
//   hcount/vcount    registered counts aligned with r/g/b
//   frame_start      one-clock pulse on the first pixel of a frame
// -----------------------------------------------------------------------------
interface vga_timing_core_if;
    logic [1:0] mode;
    logic [7:0] solid_rgb;
    logic [7:0] pix_in;
    logic       pix_req;
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    logic       hsync;
    logic       vsync;
    logic       bright;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       frame_start;

    modport master (
        input  mode, solid_rgb, pix_in,
        output pix_req, r, g, b, hsync, vsync, bright, hcount, vcount, frame_start
    );

    modport slave (
        output mode, solid_rgb, pix_in,
        input  pix_req, r, g, b, hsync, vsync, bright, hcount, vcount, frame_start
    );
endinterface

// File: rtl/vga_timing_core.sv
// -----------------------------------------------------------------------------
// vga_timing_core
// VGA raster timing generator with a built-in test-pattern source.
// A clock divider produces a pixel strobe; on each strobe the horizontal and
// vertical counters are decoded into sync/active flags and a colour, all of
// which are registered (one pixel of latency, so hcount/vcount report the
// counts the colour was computed from).
// Ports:
//   clk   system clock, all state on its rising edge
//   rst   asynchronous active-low reset
//   vif   vga_timing_core_if.master (pattern inputs and video outputs)
// Configuration constraint: H_TOTAL and V_TOTAL must not exceed 1024 since
// the counters are 10 bits wide; CHK_SH must be below 10.
// -----------------------------------------------------------------------------
module vga_timing_core #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 4,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int BAR_W     = 80,
    parameter int CHK_SH    = 5
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_core_if.master vif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam int                BAR_CW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BAR_CW-1:0] BAR_LAST = BAR_CW'(BAR_W - 1);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Region bounds are 11 bits so an end bound of exactly 1024 still compares correctly
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] H_SS      = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE      = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] V_SS      = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SE      = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = (HSYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic VS_ON = (VSYNC_POL != 0) ? 1'b1 : 1'b0;

    logic [DIV_W-1:0]  div_r;
    logic [9:0]        hc_r;
    logic [9:0]        vc_r;
    logic [2:0]        bar_idx_r;
    logic [BAR_CW-1:0] bar_cnt_r;
    logic [1:0]        mode_r;
    logic [7:0]        rgb_r;
    logic              hsync_r;
    logic              vsync_r;
    logic              bright_r;
    logic [9:0]        hcount_r;
    logic [9:0]        vcount_r;
    logic              frame_start_r;

    logic              ce_s;
    logic              h_wrap_s;
    logic              v_wrap_s;
    logic              h_act_s;
    logic              active_s;
    logic              hs_act_s;
    logic              vs_act_s;
    logic [10:0]       hc_ext_s;
    logic [10:0]       vc_ext_s;
    logic [7:0]        rgb_next_s;

    assign ce_s     = (CLK_DIV == 1) ? 1'b1 : (div_r == DIV_LAST);
    assign h_wrap_s = (hc_r == H_LAST);
    assign v_wrap_s = (vc_r == V_LAST);
    assign hc_ext_s = {1'b0, hc_r};
    assign vc_ext_s = {1'b0, vc_r};
    assign h_act_s  = (hc_ext_s < H_ACT_END);
    assign active_s = h_act_s && (vc_ext_s < V_ACT_END);
    assign hs_act_s = (hc_ext_s >= H_SS) && (hc_ext_s < H_SE);
    assign vs_act_s = (vc_ext_s >= V_SS) && (vc_ext_s < V_SE);

    // Pattern colour for the pixel the counters currently point at
    always_comb begin
        rgb_next_s = 8'h00;
        if (active_s) begin
            case (mode_r)
                2'b00:   rgb_next_s = vif.solid_rgb;
                2'b01:   rgb_next_s = {{3{bar_idx_r[2]}}, {3{bar_idx_r[1]}}, {2{bar_idx_r[0]}}};
                2'b10:   rgb_next_s = (hc_r[CHK_SH] ^ vc_r[CHK_SH]) ? 8'hFF : 8'h00;
                2'b11:   rgb_next_s = vif.pix_in;
                default: rgb_next_s = 8'h00;
            endcase
        end else begin
            rgb_next_s = 8'h00;
        end
    end

    // Clock divider producing the pixel strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_r <= {DIV_W{1'b0}};
        end else if (CLK_DIV > 1) begin
            if (div_r == DIV_LAST) begin
                div_r <= {DIV_W{1'b0}};
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end else begin
            div_r <= {DIV_W{1'b0}};
        end
    end

    // Horizontal and vertical raster counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hc_r <= 10'd0;
            vc_r <= 10'd0;
        end else if (ce_s) begin
            if (h_wrap_s) begin
                hc_r <= 10'd0;
                vc_r <= v_wrap_s ? 10'd0 : (vc_r + 10'd1);
            end else begin
                hc_r <= hc_r + 10'd1;
            end
        end
    end

    // Colour-bar index: restarted as the line wraps so hc=0 always sees bar 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bar_idx_r <= 3'd0;
            bar_cnt_r <= {BAR_CW{1'b0}};
        end else if (ce_s) begin
            if (h_wrap_s) begin
                bar_idx_r <= 3'd0;
                bar_cnt_r <= {BAR_CW{1'b0}};
            end else if (h_act_s) begin
                if (bar_cnt_r == BAR_LAST) begin
                    bar_cnt_r <= {BAR_CW{1'b0}};
                    if (bar_idx_r != 3'd7) begin
                        bar_idx_r <= bar_idx_r + 3'd1;
                    end
                end else begin
                    bar_cnt_r <= bar_cnt_r + BAR_CW'(1);
                end
            end
        end
    end

    // Mode shadow: only reloaded on the last pixel of a frame so a frame never mixes patterns
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_r <= 2'b00;
        end else if (ce_s && h_wrap_s && v_wrap_s) begin
            mode_r <= vif.mode;
        end
    end

    // Registered video outputs, updated once per pixel strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_r    <= 8'h00;
            hsync_r  <= ~HS_ON;
            vsync_r  <= ~VS_ON;
            bright_r <= 1'b0;
            hcount_r <= 10'd0;
            vcount_r <= 10'd0;
        end else if (ce_s) begin
            rgb_r    <= rgb_next_s;
            hsync_r  <= hs_act_s ? HS_ON : ~HS_ON;
            vsync_r  <= vs_act_s ? VS_ON : ~VS_ON;
            bright_r <= active_s;
            hcount_r <= hc_r;
            vcount_r <= vc_r;
        end
    end

    // Frame-start pulse: evaluated every clock so it lasts exactly one clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= ce_s && (hc_r == 10'd0) && (vc_r == 10'd0);
        end
    end

    assign vif.pix_req     = ce_s && active_s && (mode_r == 2'b11);
    assign vif.r           = rgb_r[7:5];
    assign vif.g           = rgb_r[4:2];
    assign vif.b           = rgb_r[1:0];
    assign vif.hsync       = hsync_r;
    assign vif.vsync       = vsync_r;
    assign vif.bright      = bright_r;
    assign vif.hcount      = hcount_r;
    assign vif.vcount      = vcount_r;
    assign vif.frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_core.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_core
// Directed bench for vga_timing_core with a small raster: 8/2/2/2 by 4/1/1/1,
// two clocks per pixel. An independent timing model predicts each pixel's
// outputs; predictions are queued as the strobe is driven and compared once
// the registered outputs appear.
// -----------------------------------------------------------------------------
module tb_vga_timing_core;

    localparam int H_ACTIVE   = 8;
    localparam int H_FP       = 2;
    localparam int H_SYNC     = 2;
    localparam int H_BP       = 2;
    localparam int V_ACTIVE   = 4;
    localparam int V_FP       = 1;
    localparam int V_SYNC     = 1;
    localparam int V_BP       = 1;
    localparam int CLK_DIV    = 2;
    localparam int BAR_W      = 1;
    localparam int CHK_SH     = 1;
    localparam int H_TOTAL    = 14;
    localparam int V_TOTAL    = 7;
    localparam int FRAME_CLKS = H_TOTAL * V_TOTAL * CLK_DIV;

    typedef struct {
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
        logic       br;
        logic [9:0] hc;
        logic [9:0] vc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    vga_timing_core_if vif();

    vga_timing_core #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CLK_DIV(CLK_DIV), .HSYNC_POL(0), .VSYNC_POL(0),
        .BAR_W(BAR_W), .CHK_SH(CHK_SH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vif (vif)
    );

    always #5 clk = ~clk;

    exp_t       sb_q[$];
    int         total = 0;
    int         bad   = 0;
    int         m_div = 0;
    int         m_hc  = 0;
    int         m_vc  = 0;
    logic [1:0] m_mode = 2'b00;
    bit         ramp_en = 1'b0;
    int         clk_idx = 0;
    int         last_fs = -1;
    int         rel_idx = 0;
    logic [7:0] bar_tab [8] = '{8'h00, 8'h03, 8'h1C, 8'h1F, 8'hE0, 8'hE3, 8'hFC, 8'hFF};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (clk %0d)", tag, obs, exp, clk_idx);
        end
    endtask

    function automatic logic [7:0] exp_rgb(input int hc, input int vc, input logic [1:0] md,
                                           input logic [7:0] solid, input logic [7:0] pix);
        int         i;
        logic [2:0] ib;
        if (hc >= H_ACTIVE || vc >= V_ACTIVE) return 8'h00;
        case (md)
            2'd0: return solid;
            2'd1: begin
                i = hc / BAR_W;
                if (i > 7) i = 7;
                ib = 3'(i);
                return {{3{ib[2]}}, {3{ib[1]}}, {2{ib[0]}}};
            end
            2'd2: return ((((hc >> CHK_SH) ^ (vc >> CHK_SH)) & 1) != 0) ? 8'hFF : 8'h00;
            default: return pix;
        endcase
    endfunction

    // One system clock: predict, let the DUT clock, then compare
    task automatic tick();
        exp_t       it;
        bit         ce_now;
        bit         exp_fs;
        bit         exp_req;
        logic [1:0] mode_in;
        ce_now = (m_div == CLK_DIV - 1);
        if (ramp_en) vif.pix_in = 8'((m_hc * 37 + m_vc * 11 + 5) % 256);
        #1;
        exp_req = ce_now && (m_hc < H_ACTIVE) && (m_vc < V_ACTIVE) && (m_mode == 2'b11);
        chk("pix_req", 32'(vif.pix_req), 32'(exp_req));
        mode_in = vif.mode;
        if (ce_now) begin
            it.rgb = exp_rgb(m_hc, m_vc, m_mode, vif.solid_rgb, vif.pix_in);
            it.hs  = !((m_hc >= H_ACTIVE + H_FP) && (m_hc < H_ACTIVE + H_FP + H_SYNC));
            it.vs  = !((m_vc >= V_ACTIVE + V_FP) && (m_vc < V_ACTIVE + V_FP + V_SYNC));
            it.br  = (m_hc < H_ACTIVE) && (m_vc < V_ACTIVE);
            it.hc  = 10'(m_hc);
            it.vc  = 10'(m_vc);
            sb_q.push_back(it);
        end
        exp_fs = ce_now && (m_hc == 0) && (m_vc == 0);
        @(posedge clk);
        @(negedge clk);
        clk_idx++;
        chk("frame_start", 32'(vif.frame_start), 32'(exp_fs));
        if (vif.frame_start) begin
            if (last_fs >= 0) chk("fs_period", 32'(clk_idx - last_fs), 32'(FRAME_CLKS));
            else              chk("fs_first",  32'(clk_idx - rel_idx), 32'(CLK_DIV));
            last_fs = clk_idx;
        end
        if (ce_now) begin
            it = sb_q.pop_front();
            chk("rgb",    32'({vif.r, vif.g, vif.b}), 32'(it.rgb));
            chk("hsync",  32'(vif.hsync),  32'(it.hs));
            chk("vsync",  32'(vif.vsync),  32'(it.vs));
            chk("bright", 32'(vif.bright), 32'(it.br));
            chk("hcount", 32'(vif.hcount), 32'(it.hc));
            chk("vcount", 32'(vif.vcount), 32'(it.vc));
            if (m_mode == 2'b01 && m_hc < H_ACTIVE && m_vc < V_ACTIVE)
                chk("bar_tab", 32'({vif.r, vif.g, vif.b}), 32'(bar_tab[m_hc]));
            if (m_mode == 2'b10 && m_hc == 2 && m_vc == 0)
                chk("chk_h2v0", 32'({vif.r, vif.g, vif.b}), 32'(8'hFF));
            if (m_hc == H_TOTAL - 1) begin
                m_hc = 0;
                if (m_vc == V_TOTAL - 1) begin
                    m_vc   = 0;
                    m_mode = mode_in;
                end else begin
                    m_vc++;
                end
            end else begin
                m_hc++;
            end
        end
        m_div = (m_div + 1) % CLK_DIV;
    endtask

    // Assert reset, check the reset state, release at a falling clock edge
    task automatic do_reset(input int cycles);
        rst = 1'b0;
        #1;
        chk("rst_hsync",  32'(vif.hsync),  32'(1'b1));
        chk("rst_vsync",  32'(vif.vsync),  32'(1'b1));
        chk("rst_rgb",    32'({vif.r, vif.g, vif.b}), 32'(8'h00));
        chk("rst_bright", 32'(vif.bright), 32'(1'b0));
        chk("rst_fs",     32'(vif.frame_start), 32'(1'b0));
        chk("rst_hcount", 32'(vif.hcount), 32'(10'd0));
        chk("rst_vcount", 32'(vif.vcount), 32'(10'd0));
        repeat (cycles) @(negedge clk);
        chk("rst_hold_pix_req", 32'(vif.pix_req), 32'(1'b0));
        chk("rst_hold_hcount",  32'(vif.hcount),  32'(10'd0));
        rst     = 1'b1;
        m_div   = 0;
        m_hc    = 0;
        m_vc    = 0;
        m_mode  = 2'b00;
        last_fs = -1;
        rel_idx = clk_idx;
        sb_q.delete();
    endtask

    initial begin
        rst           = 1'b1;
        vif.mode      = 2'b00;
        vif.solid_rgb = 8'hA5;
        vif.pix_in    = 8'h00;
        #2;
        do_reset(3);

        // Solid colour, two full frames
        repeat (2 * FRAME_CLKS + 4) tick();

        // Colour bars from the next frame on
        vif.mode = 2'b01;
        repeat (2 * FRAME_CLKS) tick();

        // Back to solid, then switch to checker in the middle of a frame
        vif.mode = 2'b00;
        repeat (FRAME_CLKS) tick();
        for (int k = 0; k < FRAME_CLKS && m_vc != 2; k++) tick();
        vif.mode = 2'b10;
        repeat (2 * FRAME_CLKS) tick();

        // External pixels driven as a ramp derived from the raster position
        vif.mode = 2'b11;
        ramp_en  = 1'b1;
        repeat (2 * FRAME_CLKS) tick();

        // Reset in the middle of both sync pulses
        for (int k = 0; k < 2 * FRAME_CLKS && !(m_hc == 11 && m_vc == 5 && m_div == 0); k++) tick();
        chk("pre_rst_hsync", 32'(vif.hsync), 32'(1'b0));
        chk("pre_rst_vsync", 32'(vif.vsync), 32'(1'b0));
        ramp_en  = 1'b0;
        vif.mode = 2'b00;
        do_reset(3);
        repeat (FRAME_CLKS + 8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
